// File: rtl/req_encoder_rr.sv
// Sequential round-robin request encoder: latches request pulses as sticky pending
// bits and offers one granted source index at a time on a valid/ready port.
module req_encoder_rr #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_d;
  logic [W-1:0]   idx_d;
  logic           valid_d;
  logic [N-1:0]   pending_d;
  logic           overflow_d;
  logic           handshake;
  logic [N-1:0]   served;
  logic           sel_found;
  logic [W-1:0]   sel_idx;

  // Round-robin search over the registered pending vector, starting at ptr and
  // wrapping at N (not 2**W), so non-power-of-two N never yields an index >= N.
  always_comb begin
    int           j;
    logic [W-1:0] cand;
    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned infers a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      cand = W'(j);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Capture path: the bit being served this cycle is cleared, but a request on
  // that same bit re-arms it and does not count as an overflow.
  always_comb begin
    handshake  = out_valid & out_ready;
    served     = handshake ? (ONE << out_idx) : '0;
    pending_d  = (pending & ~served) | (en ? req : '0);
    overflow_d = en & (|(req & pending & ~served));
  end

  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    idx_d   = out_idx;
    ptr_d   = ptr;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ptr_d   = (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      // clr wins over both capture and handshake in the same cycle.
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_idx   <= idx_d;
      ptr       <= ptr_d;
      pending   <= pending_d;
      overflow  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_req_encoder_rr.sv
// Directed self-checking bench for req_encoder_rr (N=4): capture, round-robin
// order, hold under back-pressure, overflow, re-arm, clear and async reset.
module tb_req_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [3:0] req;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_idx;
  logic [3:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  req_encoder_rr #(.N(4), .W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; req = 4'b0000; out_ready = 1'b0;
    step(); step();
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_idx",      32'(out_idx),   32'd0);
    check("rst_pending",  32'(pending),   32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    rst_n = 1'b1;

    // Single request: latency and handshake.
    en = 1'b1; out_ready = 1'b1; req = 4'b0100;
    step();
    check("t2_pend_e1",  32'(pending),   32'h4);
    check("t2_valid_e1", 32'(out_valid), 32'd0);
    req = 4'b0000;
    step();
    check("t2_valid_e2", 32'(out_valid), 32'd1);
    check("t2_idx_e2",   32'(out_idx),   32'd2);
    step();
    check("t2_pend_e3",  32'(pending),   32'h0);
    check("t2_valid_e3", 32'(out_valid), 32'd0);

    // ptr=3 now: pending 0101 grants 0 first (wrap), then 2.
    req = 4'b0101;
    step();
    check("t5_pend", 32'(pending), 32'h5);
    req = 4'b0000;
    step();
    check("t5_idx_a", 32'(out_idx), 32'd0);
    step();
    check("t5_bubble", 32'(out_valid), 32'd0);
    step();
    check("t5_valid_b", 32'(out_valid), 32'd1);
    check("t5_idx_b",   32'(out_idx),   32'd2);
    step();

    // Clear resets ptr to 0.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_pend",  32'(pending),   32'h0);

    // All four requests: grants 0,1,2,3, one every two cycles.
    req = 4'b1111;
    step();
    check("t3_pend", 32'(pending), 32'hF);
    req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_idx",   32'(out_idx),   32'(k));
      step();
      check("t3_bubble", 32'(out_valid), 32'd0);
    end
    check("t3_pend_end", 32'(pending), 32'h0);
    // ptr back at 0: 1001 grants 0 before 3.
    req = 4'b1001;
    step();
    req = 4'b0000;
    step();
    check("t3_ptr0_idx", 32'(out_idx), 32'd0);
    step();
    step();
    check("t3_ptr0_idx2", 32'(out_idx), 32'd3);
    step();

    // Back-pressure with overflow. ptr=0.
    req = 4'b0010;
    step();
    req = 4'b0000; out_ready = 1'b0;
    step();
    check("t4_idx_hold", 32'(out_idx), 32'd1);
    req = 4'b0001;
    step();
    check("t4_ovf_a",  32'(overflow), 32'd0);
    check("t4_pend_a", 32'(pending),  32'h3);
    req = 4'b0010;
    step();
    check("t4_ovf_b",  32'(overflow), 32'd1);
    check("t4_pend_b", 32'(pending),  32'h3);
    req = 4'b0000;
    step();
    check("t4_ovf_c", 32'(overflow), 32'd0);
    step();
    step();
    check("t4_valid_held", 32'(out_valid), 32'd1);
    check("t4_idx_held",   32'(out_idx),   32'd1);
    out_ready = 1'b1;
    step();
    check("t4_pend_after", 32'(pending), 32'h1);
    step();
    check("t4_next_idx", 32'(out_idx), 32'd0);
    step();

    // Handshake with same-cycle req on the served bit re-arms it. ptr=1.
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    check("t6_idx", 32'(out_idx), 32'd2);
    req = 4'b0100;
    step();
    req = 4'b0000;
    check("t6_rearm_pend",  32'(pending),   32'h4);
    check("t6_rearm_valid", 32'(out_valid), 32'd0);
    check("t6_rearm_ovf",   32'(overflow),  32'd0);
    step();
    check("t6_regrant_valid", 32'(out_valid), 32'd1);
    check("t6_regrant_idx",   32'(out_idx),   32'd2);
    step();

    // clr beats req and handshake together.
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    check("t6c_idx", 32'(out_idx), 32'd1);
    req = 4'b0010; clr = 1'b1;
    step();
    req = 4'b0000; clr = 1'b0;
    check("t6c_pend",  32'(pending),   32'h0);
    check("t6c_valid", 32'(out_valid), 32'd0);
    check("t6c_idx0",  32'(out_idx),   32'd0);
    check("t6c_ovf",   32'(overflow),  32'd0);
    step();
    check("t6c_idle", 32'(out_valid), 32'd0);

    // en=0 blocks capture.
    en = 1'b0; req = 4'b1111;
    step();
    check("en0_pend", 32'(pending),  32'h0);
    check("en0_ovf",  32'(overflow), 32'd0);
    en = 1'b1; req = 4'b0000;

    // Async reset in HOLD takes effect without a clock edge.
    req = 4'b1000;
    step();
    req = 4'b0000; out_ready = 1'b0;
    step();
    check("t1_hold_idx", 32'(out_idx), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_valid", 32'(out_valid), 32'd0);
    check("t1_async_idx",   32'(out_idx),   32'd0);
    check("t1_async_pend",  32'(pending),   32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("t1_after_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
